// File: rtl/autorange_ctrl.sv
// autorange_ctrl: measurement sequencer that picks an analog front-end range.
// Each measurement settles the AFE, runs one conversion and evaluates the
// saturation flags. A saturated reading steps the range up or down and repeats;
// a clean reading (or saturation at either end of the scale) finishes it.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   start_i                       measurement request (sampled in IDLE only)
//   conv_done_i, conv_error_i     converter completion / fault pulses
//   sat_hi_i, sat_lo_i, result_i  converter flags and count, valid with conv_done_i
//   conv_start_o                  one-cycle conversion request
//   range_sel_o                   range currently applied to the AFE
//   busy_o, meas_valid_o          sequence active / one-cycle result strobe
//   overrange_o, underrange_o     saturated at the largest / most sensitive range
//   error_o                       fault, timeout or oscillation; sticky until next start
//   meas_result_o, meas_range_o   latched result and the range it was taken on
module autorange_ctrl #(
  parameter int RANGE_SEL_WIDTH = 2,
  parameter int NUM_RANGES      = 4,
  parameter int SETTLE_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES  = 65535,
  parameter int MAX_STEPS       = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       conv_done_i,
  input  logic                       conv_error_i,
  input  logic                       sat_hi_i,
  input  logic                       sat_lo_i,
  input  logic [31:0]                result_i,
  output logic                       conv_start_o,
  output logic [RANGE_SEL_WIDTH-1:0] range_sel_o,
  output logic                       busy_o,
  output logic                       meas_valid_o,
  output logic                       overrange_o,
  output logic                       underrange_o,
  output logic                       error_o,
  output logic [31:0]                meas_result_o,
  output logic [RANGE_SEL_WIDTH-1:0] meas_range_o
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(MAX_STEPS + 1);
  localparam int RW = RANGE_SEL_WIDTH;

  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] STEP_MAX    = PW'(MAX_STEPS);
  localparam logic [RW-1:0] RANGE_TOP   = RW'(NUM_RANGES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CONVERT, S_EVAL, S_DONE, S_ERROR
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [PW-1:0] step_cnt;
  logic [RW-1:0] range_q;
  logic [31:0]   cap_result;
  logic          cap_hi, cap_lo;
  logic [31:0]   meas_result_q;
  logic [RW-1:0] meas_range_q;
  logic          err_q, ovr_q, und_q;

  // EVAL decision strobes, produced alongside the next state
  logic range_up, range_dn, set_ovr, set_und;

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_n;
  end

  // next state
  always_comb begin
    state_n  = state;
    range_up = 1'b0;
    range_dn = 1'b0;
    set_ovr  = 1'b0;
    set_und  = 1'b0;
    case (state)
      S_IDLE:   if (start_i) state_n = S_SETTLE;
      S_SETTLE: if (settle_cnt == '0) state_n = S_CONVERT;
      S_CONVERT: begin
        // a fault wins over a simultaneous done
        if (conv_error_i)            state_n = S_ERROR;
        else if (conv_done_i)        state_n = S_EVAL;
        else if (tmo_cnt == TMO_LAST) state_n = S_ERROR;
      end
      S_EVAL: begin
        if (cap_hi && cap_lo) begin
          state_n = S_ERROR;
        end else if (cap_hi) begin
          if (range_q < RANGE_TOP) begin
            // step budget exhausted: the loop is oscillating
            if (step_cnt == STEP_MAX) state_n = S_ERROR;
            else begin range_up = 1'b1; state_n = S_SETTLE; end
          end else begin
            set_ovr = 1'b1;
            state_n = S_DONE;
          end
        end else if (cap_lo) begin
          if (range_q != '0) begin
            if (step_cnt == STEP_MAX) state_n = S_ERROR;
            else begin range_dn = 1'b1; state_n = S_SETTLE; end
          end else begin
            set_und = 1'b1;
            state_n = S_DONE;
          end
        end else begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERROR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // counters, captured data and status registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      settle_cnt    <= '0;
      tmo_cnt       <= '0;
      step_cnt      <= '0;
      range_q       <= RANGE_TOP;
      cap_result    <= '0;
      cap_hi        <= 1'b0;
      cap_lo        <= 1'b0;
      meas_result_q <= '0;
      meas_range_q  <= '0;
      err_q         <= 1'b0;
      ovr_q         <= 1'b0;
      und_q         <= 1'b0;
    end else begin
      if (state_n == S_ERROR) err_q <= 1'b1;
      case (state)
        S_IDLE: if (start_i) begin
          settle_cnt <= SETTLE_LOAD;
          step_cnt   <= '0;
          err_q      <= 1'b0;
          ovr_q      <= 1'b0;
          und_q      <= 1'b0;
        end
        S_SETTLE: begin
          // timeout counter is zeroed on the way into CONVERT, so it also
          // marks the first CONVERT cycle
          if (settle_cnt != '0) settle_cnt <= settle_cnt - SW'(1);
          else                  tmo_cnt    <= '0;
        end
        S_CONVERT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (conv_done_i && !conv_error_i) begin
            cap_result <= result_i;
            cap_hi     <= sat_hi_i;
            cap_lo     <= sat_lo_i;
          end
        end
        S_EVAL: begin
          if (range_up || range_dn) begin
            step_cnt   <= step_cnt + PW'(1);
            settle_cnt <= SETTLE_LOAD;
          end
          if (range_up) range_q <= range_q + RW'(1);
          if (range_dn) range_q <= range_q - RW'(1);
          if (state_n == S_DONE) begin
            meas_result_q <= cap_result;
            meas_range_q  <= range_q;
          end
          if (set_ovr) ovr_q <= 1'b1;
          if (set_und) und_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // outputs
  always_comb begin
    conv_start_o = (state == S_CONVERT) && (tmo_cnt == '0);
    busy_o       = (state != S_IDLE);
    meas_valid_o = (state == S_DONE);
  end

  assign range_sel_o   = range_q;
  assign overrange_o   = ovr_q;
  assign underrange_o  = und_q;
  assign error_o       = err_q;
  assign meas_result_o = meas_result_q;
  assign meas_range_o  = meas_range_q;

endmodule
